// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, PC+4
// adder, instruction-memory address drive and IF/ID pipeline register.
// Optional build macro: IF_STALL_CNT_EN. When it is defined, a saturating
// stall-cycle counter is built. When it is undefined, stall_cnt_o is tied to 0.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write_i,
  input  logic        ifid_write_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_s;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  // PC+4 adder; the sum wraps modulo 2^32.
  assign pc_plus4_s = pc_q + 32'd4;

  // Next PC: a redirect beats a stall, and the target is forced word-aligned.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (pc_write_i) begin
      pc_d = pc_plus4_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // Next IF/ID contents: a flush beats a held IF/ID register.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (redirect_i) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_valid_d = 1'b0;
    end else if (ifid_write_i) begin
      ifid_instr_d = imem_rdata_i;
      ifid_pc4_d   = pc_plus4_s;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
    end
  end

  // PC and IF/ID registers. Reset is asynchronous and leaves a bubble in IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // A stall cycle is one where the PC neither advances nor is redirected.
  // The counter saturates at 32'hFFFF_FFFF and does not wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write_i && !redirect_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'h0000_0000;
`endif

  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_valid_o = ifid_valid_q;

endmodule
